ldl_p1ram_v2: RTL
=================

Name: ldl_p1ram_v2

Overview:
Parametrised single-port synchronous RAM and the successor to the v1 single-port RAM.
- Adds byte-lane write enables, a configurable read pipeline (1..3 cycles) with a read-valid strobe, and a selectable read-during-write mode.
- Adds a hardware init sequencer that writes INIT_VAL to every word after reset.
- Used as the generic buffer and table store under FIFOs, caches and lookup tables in the memory library.

Parameters:
DWIDTH, 32, data word width; must be a multiple of BWIDTH
DEEPTH, 1024, number of words; need not be a power of two
AWIDTH, $clog2(DEEPTH), address width
BWIDTH, 8, byte-lane width
NBE, DWIDTH/BWIDTH, number of byte lanes (derived, do not override)
RDLAT, 1, read latency in cycles, legal 1..3; elaboration error otherwise
RDW_MODE, 0, same-cycle read+write: 0 read-first (old data), 1 write-first (new data), 2 no-change (read suppressed)
INIT_VAL, 0, DWIDTH-bit value written to every word by the init sweep

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
re  input  1  read request, sampled when init_busy=0
we  input  1  write request, sampled when init_busy=0
be  input  NBE  byte-lane write enables; lane i covers din[i*BWIDTH +: BWIDTH]
addr  input  AWIDTH  word address for read and write
din  input  DWIDTH  write data
dout  output  DWIDTH  read data, registered
dout_vld  output  1  one-cycle strobe: dout carries data for a read issued RDLAT cycles earlier
init_busy  output  1  high during reset and init sweep; requests ignored while high

Behaviour:
- Reset (rst_n=0 at a rising edge): dout=0, dout_vld=0, init_busy=1, read pipeline valid bits cleared, FSM to INIT, sweep counter=0. Memory contents are not reset directly; the sweep overwrites them.
- FSM has two states, INIT and RUN.
- INIT: each cycle writes INIT_VAL to mem[cnt] (all lanes), then cnt+1.
  - After writing DEEPTH-1, go to RUN; init_busy falls on the same edge.
  - The sweep takes exactly DEEPTH cycles after rst_n rises; init_busy=1 for those DEEPTH cycles.
- Reset mid-sweep or mid-RUN: the sweep restarts from 0 and in-flight reads are dropped (no dout_vld).
- RUN: a request is accepted when init_busy=0. re/we/be/addr/din presented while busy are ignored entirely.
- Write: for each lane i with we=1 and be[i]=1, write that lane of mem[addr] on the edge. we=1 with be=0 is a no-op.
- Read: re=1 captures mem[addr] on that edge into pipeline stage 1, then shifts through RDLAT-1 further register stages.
  - dout updates and dout_vld=1 exactly RDLAT cycles after the accepting edge.
  - dout holds its last value otherwise; dout_vld=0 otherwise.
  - Back-to-back reads are fully pipelined: one result per cycle.
- Same cycle re=1 and we=1 (single address):
  - RDW_MODE 0: read returns the pre-write word.
  - RDW_MODE 1: read returns the post-write word; unwritten lanes keep their old bytes, written lanes take din.
  - RDW_MODE 2: the write occurs, the read is dropped, no dout_vld for that slot, dout unchanged.
- Out-of-range address (addr >= DEEPTH, only possible when DEEPTH is not a power of two): the write is dropped; the read returns 0 with dout_vld=1.
- The memory array is inferable as block RAM. Only the RDLAT-1 extra stages are flops; stage 1 is the RAM output register.
- Simulation only: on elaboration, display the instance path, DWIDTH, DEEPTH and RDLAT.

Test Plan:
- Init sweep: DEEPTH=16, INIT_VAL=32'hA5A5A5A5; release rst_n.
  - Expect init_busy high for exactly 16 cycles.
  - Reading addresses 0..15 then returns A5A5A5A5 each, dout_vld once per read.
- Byte enables: write addr 3 din=32'h11223344 be=4'b1111, then din=32'hFFFFFFFF be=4'b0101.
  - Expect a read of addr 3 to return 32'h11FF33FF.
- Latency: with RDLAT=1,2,3, issue reads of addr 0..7 back-to-back.
  - Expect dout_vld a contiguous 8-cycle burst starting RDLAT cycles after the first re, with data in order.
- Read-during-write: mem[5]=32'h0; same cycle re=1 we=1 addr=5 din=32'hDEADBEEF be=4'b0011.
  - Expect dout=0 (mode 0); dout=32'h0000BEEF (mode 1); no dout_vld and dout unchanged (mode 2).
  - In all modes a later read of addr 5 returns 32'h0000BEEF.
- Reset mid-operation: reads in flight, plus rst_n low for 1 cycle at sweep cnt=7.
  - Expect no dout_vld for the dropped reads, dout=0, and the sweep restarting at 0 with a full DEEPTH-cycle init_busy.
  - A write attempted while busy must not change memory.
- Out-of-range: DEEPTH=10; write addr 12 din=32'h12345678, then read addr 12 and addr 2.
  - Expect addr 12 to return 0 with dout_vld, and mem[2] to still equal INIT_VAL.

Source files
------------

// File: rtl/ldl_p1ram_v2.sv
// Single-port synchronous RAM with byte-lane writes, 1..3 cycle read pipeline,
// selectable read-during-write behaviour and a post-reset init sweep.
module ldl_p1ram_v2 #(
    parameter int unsigned        DWIDTH   = 32,
    parameter int unsigned        DEEPTH   = 1024,
    parameter int unsigned        AWIDTH   = $clog2(DEEPTH),
    parameter int unsigned        BWIDTH   = 8,
    parameter int unsigned        NBE      = DWIDTH / BWIDTH,
    parameter int unsigned        RDLAT    = 1,
    parameter int unsigned        RDW_MODE = 0,
    parameter logic [DWIDTH-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic              we,
    input  logic [NBE-1:0]    be,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic              dout_vld,
    output logic              init_busy
);

    if (RDLAT < 1 || RDLAT > 3) begin : g_bad_rdlat
        $error("ldl_p1ram_v2: RDLAT must be 1..3");
    end
    if (RDW_MODE > 2) begin : g_bad_rdw
        $error("ldl_p1ram_v2: RDW_MODE must be 0..2");
    end
    if (DWIDTH % BWIDTH != 0) begin : g_bad_bwidth
        $error("ldl_p1ram_v2: DWIDTH must be a multiple of BWIDTH");
    end

`ifndef SYNTHESIS
    initial $display("%m: DWIDTH=%0d DEEPTH=%0d RDLAT=%0d", DWIDTH, DEEPTH, RDLAT);
`endif

    localparam logic [AWIDTH:0]   DepthW   = (AWIDTH + 1)'(DEEPTH);
    localparam logic [AWIDTH-1:0] LastAddr = AWIDTH'(DEEPTH - 1);

    typedef enum logic {StInit, StRun} state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic              init_busy_q, init_busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_busy_d = init_busy_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d     = StRun;
                    init_busy_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            StRun: ;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            init_busy_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_busy_q <= init_busy_d;
        end
    end

    assign init_busy = init_busy_q;

    // Request decode; addresses past DEEPTH never touch the array.
    logic              in_range;
    logic              wr_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic [NBE-1:0]    wr_be;

    assign in_range = ({1'b0, addr} < DepthW);

    always_comb begin
        if (init_busy_q) begin
            wr_en   = rst_n;
            wr_addr = cnt_q;
            wr_data = INIT_VAL;
            wr_be   = '1;
        end else begin
            wr_en   = rst_n && we && in_range;
            wr_addr = addr;
            wr_data = din;
            wr_be   = be;
        end
    end

    logic [DWIDTH-1:0] mem_q [DEEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NBE; i++) begin
            if (wr_en && wr_be[i]) begin
                mem_q[wr_addr][i*BWIDTH +: BWIDTH] <= wr_data[i*BWIDTH +: BWIDTH];
            end
        end
    end

    logic [DWIDTH-1:0] rd_old;
    logic [DWIDTH-1:0] rd_merged;
    logic [DWIDTH-1:0] rd_word;
    logic              rd_take;

    always_comb begin
        rd_old    = in_range ? mem_q[addr] : '0;
        rd_merged = rd_old;
        for (int i = 0; i < NBE; i++) begin
            if (we && be[i]) begin
                rd_merged[i*BWIDTH +: BWIDTH] = din[i*BWIDTH +: BWIDTH];
            end
        end
        if (!in_range) begin
            rd_word = '0;
        end else if (RDW_MODE == 1) begin
            rd_word = rd_merged;
        end else begin
            rd_word = rd_old;
        end
        rd_take = re && !init_busy_q && !(RDW_MODE == 2 && we);
    end

    // Stage 0 is the RAM output register; stages 1..RDLAT-1 are plain flops.
    logic [DWIDTH-1:0] pipe_data_q [RDLAT];
    logic [DWIDTH-1:0] pipe_data_d [RDLAT];
    logic [RDLAT-1:0]  pipe_vld_q, pipe_vld_d;

    always_comb begin
        pipe_vld_d[0]  = rd_take;
        pipe_data_d[0] = rd_take ? rd_word : pipe_data_q[0];
        for (int k = 1; k < RDLAT; k++) begin
            pipe_vld_d[k]  = pipe_vld_q[k-1];
            pipe_data_d[k] = pipe_vld_q[k-1] ? pipe_data_q[k-1] : pipe_data_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int k = 0; k < RDLAT; k++) begin
                pipe_data_q[k] <= '0;
            end
        end else begin
            pipe_vld_q <= pipe_vld_d;
            for (int k = 0; k < RDLAT; k++) begin
                pipe_data_q[k] <= pipe_data_d[k];
            end
        end
    end

    assign dout     = pipe_data_q[RDLAT-1];
    assign dout_vld = pipe_vld_q[RDLAT-1];

endmodule
